cam_capture_ctrl: RTL and testbench
===================================

# cam_capture_ctrl

Parametrised OV7670-class camera capture controller. It replaces the fixed 640×480, byte-wide capture path. All camera pins are sampled in the single system clock domain. The block generates XCLK, assembles 1- or 2-byte pixels, and writes one frame per software request into the frame-buffer RAM through a single-cycle write port. Frame-done and frame-error status go back to the Wishbone register block.

## Interface
- `H_ACTIVE`, default 640: active pixels per line.
- `V_ACTIVE`, default 480: active lines per frame.
- `PIX_BYTES`, default 2: bytes per pixel. Legal values are 1 (raw/Y) and 2 (RGB565/YUV pair).
- `ADDR_W`, default 19: frame-buffer address width. Must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE.
- `XCLK_DIV`, default 2: XCLK half-period in `clk` cycles. Must be ≥ 2.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle capture request from software.
- `abort` in 1: one-cycle cancel request.
- `cam_vsync`, `cam_href`, `cam_pclk` in 1 each: raw camera pins, asynchronous.
- `cam_data` in 8: raw camera data.
- `cam_xclk` out 1: camera master clock.
- `wr_en` out 1: frame-buffer write strobe, one cycle per pixel.
- `wr_addr` out ADDR_W: pixel address, linear, starting at 0.
- `wr_data` out 8·PIX_BYTES: pixel, first received byte in the MSBs.
- `busy` out 1: high from accepted `start` until done, abort, or reset.
- `done` out 1: one-cycle pulse at frame end.
- `frame_err` out 1: sticky error flag. Cleared by the next accepted `start`.
- `line_cnt` out 16: lines completed in the current or last frame.

## Operation
- XCLK: counter runs continuously from reset and toggles `cam_xclk` every XCLK_DIV cycles.
- Synchronisers:
  - 2-flop synchronisers on vsync, href and pclk.
  - `cam_data` passes through a 2-flop delay aligned with the pclk path.
  - A rising edge of synchronised pclk produces a one-cycle `pclk_rise`.
  - Synchronised vsync and href are edge-detected the same way.
- FSM states: IDLE, ARM, WAIT_SOF, CAPTURE.
  - IDLE: `start` → ARM. Clear `frame_err`, `line_cnt`, address and byte phase; set `busy`.
  - ARM: wait for vsync = 1. Guarantees capture begins at a clean frame boundary even if `start` lands mid-frame.
  - WAIT_SOF: vsync falling edge → CAPTURE.
  - CAPTURE: on `pclk_rise` with href = 1, shift the data byte into the pixel register and advance the byte phase. When PIX_BYTES bytes are collected, pulse `wr_en` with the current address, then increment the address. Byte phase resets to 0 on every href rising edge.
  - CAPTURE: href falling edge increments `line_cnt`. If fewer than H_ACTIVE pixels were written on that line, set `frame_err`.
  - CAPTURE: vsync rising edge → IDLE. Pulse `done`, clear `busy`. Set `frame_err` if the pixel count ≠ expected count.
- Expected pixel count is H_ACTIVE·V_ACTIVE.
- Overrun: once the address reaches the expected count, further pixels are dropped (no `wr_en`), the address holds, and `frame_err` is set.
- `abort` in any non-IDLE state → IDLE next cycle, no `done`, `busy` = 0. `abort` has priority over every other event in the same cycle.
- `start` while `busy` is ignored.
- `start` and `abort` in the same IDLE cycle: stay IDLE.

## Timing
- Reset values: every output 0, FSM in IDLE, XCLK counter 0.
- Assertion of `rst` mid-frame returns to IDLE immediately, with no `done`.
- A pin edge is visible as its internal pulse 3 `clk` cycles after it occurs (2 synchroniser flops plus the edge register).
- `wr_en` is asserted in the cycle after the `pclk_rise` of the last byte of a pixel. `wr_addr` and `wr_data` are stable in that cycle.
- `done` is asserted in the cycle after the internal vsync rising pulse.
- Pixel clock must be ≤ clk/4. With XCLK_DIV ≥ 2 this holds for camera PLL bypass.
- Address arithmetic is unsigned ADDR_W bits. It never wraps: it saturates at the expected count.

## Configuration
- `CAM_DECIMATE_EN` defined: 2× decimation in both axes.
  - Only pixels with even column index and even line index are written.
  - Addresses stay contiguous.
  - Expected count becomes (H_ACTIVE/2)·(V_ACTIVE/2); the per-line check uses H_ACTIVE/2 written pixels, applied on even lines only.
  - `line_cnt` still counts all input lines.
- `CAM_DECIMATE_EN` undefined: every pixel is written. No decimation logic is present.

## Test plan
Bench parameters: H_ACTIVE = 4, V_ACTIVE = 2, PIX_BYTES = 2, XCLK_DIV = 2, pclk = clk/8.
- Normal frame. Stimulus: `start`, then one full frame with bytes 0x01..0x10. Required response: 8 writes, addr 0..7, data 0x0102, 0x0304, …, 0x0F10; one `done`; `frame_err` = 0; `line_cnt` = 2.
- Start mid-frame. Stimulus: `start` while vsync = 0 and href is toggling. Required response: no writes until the next vsync high→low; then a correct 8-pixel frame.
- Short line. Stimulus: line 1 has only 3 pixels. Required response: 7 writes, `done`, `frame_err` = 1. The next `start` clears `frame_err` to 0.
- Overrun. Stimulus: a third line of 4 pixels. Required response: exactly 8 writes, address holds at 8, `frame_err` = 1, `done` at vsync rise.
- Abort and reset. Stimulus: `abort` after 3 writes. Required response: `busy` = 0 in the next cycle, no `done`. Stimulus: `rst` low mid-frame. Required response: all outputs 0 asynchronously, `cam_xclk` restarts from 0.
- Decimation. Stimulus: `CAM_DECIMATE_EN` build, same frame as the normal-frame case. Required response: 2 writes, data 0x0102 and 0x0506 at addr 0 and 1, `frame_err` = 0.

Source files
------------

// File: rtl/cam_capture_ctrl_if.sv
// Camera capture bundle: software control, raw camera pins and frame-buffer write port.
// slave is the controller's view, master is the driver/observer view.
interface cam_capture_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 16
) ();
    logic              start;
    logic              abort;
    logic              cam_vsync;
    logic              cam_href;
    logic              cam_pclk;
    logic [7:0]        cam_data;
    logic              cam_xclk;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [15:0]       line_cnt;

    modport master (
        output start, abort, cam_vsync, cam_href, cam_pclk, cam_data,
        input  cam_xclk, wr_en, wr_addr, wr_data, busy, done, frame_err, line_cnt
    );

    modport slave (
        input  start, abort, cam_vsync, cam_href, cam_pclk, cam_data,
        output cam_xclk, wr_en, wr_addr, wr_data, busy, done, frame_err, line_cnt
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Camera capture: XCLK gen, pin sync, pixel assembly, one frame per start (CAM_DECIMATE_EN: 2x2 decimation).
// Latency: pin edge -> internal pulse 3 clk; wr_en one clk after the last byte's pclk_rise.
// No backpressure: the frame-buffer port accepts every write; pixels past the expected count are dropped.
module cam_capture_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int PIX_BYTES = 2,
    parameter int ADDR_W    = 19,
    parameter int XCLK_DIV  = 2
) (
    input logic             clk,
    input logic             rst,
    cam_capture_ctrl_if.slave cam
);
    localparam int PIX_W = 8 * PIX_BYTES;
    localparam int XW    = (XCLK_DIV > 2) ? $clog2(XCLK_DIV) : 1;
`ifdef CAM_DECIMATE_EN
    localparam int LINE_PIX = H_ACTIVE / 2;
    localparam int EXP      = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
    localparam int LINE_PIX = H_ACTIVE;
    localparam int EXP      = H_ACTIVE * V_ACTIVE;
`endif
    // One spare bit so the saturated address can equal 2^ADDR_W.
    localparam logic [ADDR_W:0] EXP_CNT  = (ADDR_W+1)'(EXP);
    localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W+1)'(1);
    localparam logic [15:0]     LINE_TGT = 16'(LINE_PIX);
    localparam logic            PH_LAST  = 1'(PIX_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT_SOF, S_CAPTURE} state_t;

    logic [XW-1:0]     xclk_cnt_q;
    logic              xclk_q;
    logic [1:0]        vs_sync_q, hr_sync_q, pc_sync_q;
    logic              vs_prev_q, hr_prev_q, pc_prev_q;
    logic [7:0]        dat_s1_q, dat_s2_q;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              phase_q, phase_d;
    logic [7:0]        hold_q, hold_d;
    logic [15:0]       line_wr_q, line_wr_d;
    logic [15:0]       line_cnt_q, line_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic [PIX_W-1:0]  pix_next;
    logic              keep;
    logic              line_chk;
`ifdef CAM_DECIMATE_EN
    logic              col_q, col_d;
`endif

    logic vs_lvl, hr_lvl, vs_rise, vs_fall, hr_rise, hr_fall, pc_rise;
    assign vs_lvl  = vs_sync_q[1];
    assign hr_lvl  = hr_sync_q[1];
    assign vs_rise = vs_lvl & ~vs_prev_q;
    assign vs_fall = ~vs_lvl & vs_prev_q;
    assign hr_rise = hr_lvl & ~hr_prev_q;
    assign hr_fall = ~hr_lvl & hr_prev_q;
    assign pc_rise = pc_sync_q[1] & ~pc_prev_q;

    generate
        if (PIX_BYTES == 1) begin : g_pix1
            assign pix_next = dat_s2_q;
        end else begin : g_pix2
            assign pix_next = {hold_q, dat_s2_q};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xclk_cnt_q <= '0;
            xclk_q     <= 1'b0;
            vs_sync_q  <= '0;
            hr_sync_q  <= '0;
            pc_sync_q  <= '0;
            vs_prev_q  <= 1'b0;
            hr_prev_q  <= 1'b0;
            pc_prev_q  <= 1'b0;
            dat_s1_q   <= '0;
            dat_s2_q   <= '0;
        end else begin
            if (xclk_cnt_q == XW'(XCLK_DIV - 1)) begin
                xclk_cnt_q <= '0;
                xclk_q     <= ~xclk_q;
            end else begin
                xclk_cnt_q <= xclk_cnt_q + XW'(1);
            end
            vs_sync_q <= {vs_sync_q[0], cam.cam_vsync};
            hr_sync_q <= {hr_sync_q[0], cam.cam_href};
            pc_sync_q <= {pc_sync_q[0], cam.cam_pclk};
            vs_prev_q <= vs_sync_q[1];
            hr_prev_q <= hr_sync_q[1];
            pc_prev_q <= pc_sync_q[1];
            dat_s1_q  <= cam.cam_data;
            dat_s2_q  <= dat_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            hold_q     <= '0;
            line_wr_q  <= '0;
            line_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef CAM_DECIMATE_EN
            col_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            line_wr_q  <= line_wr_d;
            line_cnt_q <= line_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef CAM_DECIMATE_EN
            col_q      <= col_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        phase_d    = phase_q;
        hold_d     = hold_q;
        line_wr_d  = line_wr_q;
        line_cnt_d = line_cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef CAM_DECIMATE_EN
        col_d      = col_q;
        keep       = ~col_q & ~line_cnt_q[0];
        line_chk   = ~line_cnt_q[0];
`else
        keep       = 1'b1;
        line_chk   = 1'b1;
`endif

        if (cam.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cam.start && !cam.abort) begin
                        state_d    = S_ARM;
                        err_d      = 1'b0;
                        line_cnt_d = '0;
                        addr_d     = '0;
                        phase_d    = 1'b0;
                    end
                end
                S_ARM: begin
                    if (vs_lvl) state_d = S_WAIT_SOF;
                end
                S_WAIT_SOF: begin
                    if (vs_fall) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (hr_rise) begin
                        phase_d   = 1'b0;
                        line_wr_d = '0;
`ifdef CAM_DECIMATE_EN
                        col_d     = 1'b0;
`endif
                    end
                    if (pc_rise && hr_lvl) begin
                        hold_d  = dat_s2_q;
                        phase_d = (phase_q == PH_LAST) ? 1'b0 : ~phase_q;
                        if (phase_q == PH_LAST) begin
`ifdef CAM_DECIMATE_EN
                            col_d = ~col_q;
`endif
                            if (keep) begin
                                if (addr_q == EXP_CNT) begin
                                    err_d = 1'b1;
                                end else begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = addr_q[ADDR_W-1:0];
                                    wr_data_d = pix_next;
                                    addr_d    = addr_q + ADDR_ONE;
                                    line_wr_d = line_wr_q + 16'd1;
                                end
                            end
                        end
                    end
                    if (hr_fall) begin
                        line_cnt_d = line_cnt_q + 16'd1;
                        if (line_chk && (line_wr_q < LINE_TGT)) err_d = 1'b1;
                    end
                    if (vs_rise) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        if (addr_q != EXP_CNT) err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign cam.cam_xclk  = xclk_q;
    assign cam.wr_en     = wr_en_q;
    assign cam.wr_addr   = wr_addr_q;
    assign cam.wr_data   = wr_data_q;
    assign cam.busy      = (state_q != S_IDLE);
    assign cam.done      = done_q;
    assign cam.frame_err = err_q;
    assign cam.line_cnt  = line_cnt_q;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: 4x2 RGB565 frames driven at pclk = clk/8, checked against a pixel-list model.
module tb_cam_capture_ctrl;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int AW   = 3;
`ifdef CAM_DECIMATE_EN
    localparam bit DEC  = 1'b1;
    localparam int EXP  = (H / 2) * (V / 2);
    localparam int LPIX = H / 2;
`else
    localparam bit DEC  = 1'b0;
    localparam int EXP  = H * V;
    localparam int LPIX = H;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cam_capture_ctrl_if #(.ADDR_W(AW), .PIX_W(16)) cam ();

    cam_capture_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .PIX_BYTES(2), .ADDR_W(AW), .XCLK_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .cam(cam)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    int          wa[$];
    logic [15:0] wd[$];
    int          n_done  = 0;
    int          wr_base;
    int          done_base;

    int          f_nl;
    int          f_len[4];
    logic [7:0]  f_bytes[$];
    int          e_addr[$];
    logic [15:0] e_data[$];
    bit          e_err;

    always @(negedge clk) begin
        if (cam.wr_en === 1'b1) begin
            wa.push_back(int'(cam.wr_addr));
            wd.push_back(cam.wr_data);
        end
        if (cam.done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic mark();
        wr_base   = wa.size();
        done_base = n_done;
    endtask

    task automatic pulse_start();
        cam.start = 1'b1;
        cyc(1);
        cam.start = 1'b0;
    endtask

    task automatic set_frame(input int nl, input int l0, input int l1, input int l2, input bit seq);
        int tot;
        f_nl = nl;
        f_len[0] = l0; f_len[1] = l1; f_len[2] = l2; f_len[3] = 0;
        f_bytes.delete();
        tot = 0;
        for (int i = 0; i < nl; i++) tot += 2 * f_len[i];
        for (int k = 0; k < tot; k++) f_bytes.push_back(seq ? 8'(k + 1) : 8'($urandom));
    endtask

    // Camera timing: vsync low frames the lines, href per line, data set half a pclk before its rise.
    task automatic send_frame();
        int k;
        k = 0;
        cyc(8);
        cam.cam_vsync = 1'b0;
        cyc(8);
        for (int i = 0; i < f_nl; i++) begin
            cam.cam_href = 1'b1;
            cyc(4);
            for (int j = 0; j < 2 * f_len[i]; j++) begin
                cam.cam_data = f_bytes[k];
                k++;
                cyc(4);
                cam.cam_pclk = 1'b1;
                cyc(4);
                cam.cam_pclk = 1'b0;
            end
            cyc(4);
            cam.cam_href = 1'b0;
            cyc(8);
        end
        cam.cam_vsync = 1'b1;
        cyc(12);
    endtask

    // Pixel (i,j) is kept when decimation allows it and the frame still has room.
    task automatic model_frame();
        int w, k, lw;
        bit take;
        e_addr.delete();
        e_data.delete();
        e_err = 1'b0;
        w = 0;
        k = 0;
        for (int i = 0; i < f_nl; i++) begin
            lw = 0;
            for (int j = 0; j < f_len[i]; j++) begin
                take = DEC ? ((i % 2 == 0) && (j % 2 == 0)) : 1'b1;
                if (take) begin
                    if (w < EXP) begin
                        e_addr.push_back(w);
                        e_data.push_back({f_bytes[k], f_bytes[k + 1]});
                        w++;
                        lw++;
                    end else begin
                        e_err = 1'b1;
                    end
                end
                k += 2;
            end
            if ((!DEC || (i % 2 == 0)) && (lw < LPIX)) e_err = 1'b1;
        end
        if (w != EXP) e_err = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        int n;
        model_frame();
        n = wa.size() - wr_base;
        check($sformatf("%s_nwr", tag), n, e_addr.size());
        for (int i = 0; i < n && i < e_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa[wr_base + i], e_addr[i]);
            check($sformatf("%s_data%0d", tag, i), {16'h0, wd[wr_base + i]}, {16'h0, e_data[i]});
        end
        check($sformatf("%s_done", tag), n_done - done_base, 1);
        check($sformatf("%s_err", tag), cam.frame_err, e_err);
        check($sformatf("%s_lines", tag), cam.line_cnt, f_nl);
        check($sformatf("%s_busy", tag), cam.busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, cam.wr_en, 0);
        check({tag, "_done"}, cam.done, 0);
        check({tag, "_busy"}, cam.busy, 0);
        check({tag, "_err"}, cam.frame_err, 0);
        check({tag, "_lines"}, cam.line_cnt, 0);
        check({tag, "_addr"}, cam.wr_addr, 0);
        check({tag, "_data"}, cam.wr_data, 0);
        check({tag, "_xclk"}, cam.cam_xclk, 0);
    endtask

    initial begin
        cam.start = 1'b0; cam.abort = 1'b0;
        cam.cam_vsync = 1'b1; cam.cam_href = 1'b0; cam.cam_pclk = 1'b0; cam.cam_data = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1 check("xclk_cyc1", cam.cam_xclk, 0);
        @(posedge clk) #1 check("xclk_cyc2", cam.cam_xclk, 1);
        cyc(10);

        // start and abort together in IDLE are both dropped
        cam.start = 1'b1; cam.abort = 1'b1;
        cyc(1);
        cam.start = 1'b0; cam.abort = 1'b0;
        check("start_abort_idle", cam.busy, 0);

        // normal frame, bytes 0x01..0x10
        set_frame(2, 4, 4, 0, 1'b1);
        mark();
        pulse_start();
        check("busy_after_start", cam.busy, 1);
        send_frame();
        check_frame("normal");

        // start lands inside a frame: that frame is skipped, the next one is captured
        set_frame(2, 4, 4, 0, 1'b0);
        mark();
        fork
            send_frame();
            begin
                cyc(30);
                pulse_start();
            end
        join
        check("midframe_skipped", wa.size() - wr_base, 0);
        set_frame(2, 4, 4, 0, 1'b0);
        send_frame();
        check_frame("midframe");

        // short second line
        set_frame(2, 4, 3, 0, 1'b0);
        mark();
        pulse_start();
        send_frame();
        check_frame("short");
        pulse_start();
        check("err_cleared", cam.frame_err, 0);
        set_frame(2, 4, 4, 0, 1'b0);
        mark();
        send_frame();
        check_frame("after_short");

        // overrun: a third line
        set_frame(3, 4, 4, 4, 1'b0);
        mark();
        pulse_start();
        send_frame();
        check_frame("overrun");

        // random frames
        for (int r = 0; r < 4; r++) begin
            set_frame($urandom_range(1, 3), $urandom_range(3, 5), $urandom_range(3, 5),
                      $urandom_range(3, 5), 1'b0);
            mark();
            pulse_start();
            send_frame();
            check_frame($sformatf("rand%0d", r));
        end

        // abort after three writes
        set_frame(2, 4, 4, 0, 1'b0);
        mark();
        pulse_start();
        fork
            send_frame();
            begin
                int c;
                c = 0;
                while ((wa.size() - wr_base < 3) && (c < 3000)) begin
                    @(negedge clk);
                    c++;
                end
                check("abort_wait", (c < 3000), 1);
                @(posedge clk); #2 cam.abort = 1'b1;
                @(posedge clk); #2 cam.abort = 1'b0;
                check("abort_busy", cam.busy, 0);
            end
        join
        check("abort_nwr", wa.size() - wr_base, 3);
        check("abort_done", n_done - done_base, 0);
        check("abort_busy_end", cam.busy, 0);

        // reset mid-frame
        set_frame(2, 4, 4, 0, 1'b0);
        mark();
        pulse_start();
        fork
            send_frame();
            begin
                cyc(100);
                check("rst_prewr", (wa.size() - wr_base) > 0, 1);
                #1 rst_n = 1'b0;
                #1 check_all_zero("rst_mid");
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk) #1 check("rst_xclk1", cam.cam_xclk, 0);
                @(posedge clk) #1 check("rst_xclk2", cam.cam_xclk, 1);
            end
        join
        check("rst_done", n_done - done_base, 0);
        check("rst_busy", cam.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
